// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM-stage controller: FSM state encoding and
// the values loaded into the MEM/WB register when a bubble is inserted.
package mem_stage_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  localparam logic BUBBLE_REG_WRITE = 1'b0;
  localparam logic BUBBLE_MEM2REG   = 1'b0;

  // Word accesses must have the two low address bits clear.
  function automatic logic word_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register. Bubble has priority over load; with neither
// asserted the register holds its contents.
module mem_wb_pipe_reg
  import mem_stage_pkg::*;
#(
  parameter int data_width = 32,
  parameter int op_width   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  bubble,
  input  logic                  reg_write_m,
  input  logic                  mem2reg_m,
  input  logic [data_width-1:0] alu_result_m,
  input  logic [data_width-1:0] read_data_m,
  input  logic [op_width-1:0]   write_reg_m,
  output logic                  reg_write_w,
  output logic                  mem2reg_w,
  output logic [data_width-1:0] alu_result_w,
  output logic [data_width-1:0] read_data_w,
  output logic [op_width-1:0]   write_reg_w
);

  // Capture retiring instruction, insert bubble, or hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_w  <= 1'b0;
      mem2reg_w    <= 1'b0;
      alu_result_w <= '0;
      read_data_w  <= '0;
      write_reg_w  <= '0;
    end else if (bubble) begin
      reg_write_w  <= BUBBLE_REG_WRITE;
      mem2reg_w    <= BUBBLE_MEM2REG;
      alu_result_w <= '0;
      read_data_w  <= '0;
      write_reg_w  <= '0;
    end else if (load) begin
      reg_write_w  <= reg_write_m;
      mem2reg_w    <= mem2reg_m;
      alu_result_w <= alu_result_m;
      read_data_w  <= read_data_m;
      write_reg_w  <= write_reg_m;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: drives the data-memory req/ready port from the
// EX/MEM register, stalls upstream during wait states, flags misaligned
// accesses and wait timeouts, and feeds the MEM/WB register.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int data_width = 32,
  parameter int op_width   = 5,
  parameter int timeout    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write_m,
  input  logic                  mem2reg_m,
  input  logic                  mem_write_m,
  input  logic [data_width-1:0] alu_result_m,
  input  logic [data_width-1:0] write_data_m,
  input  logic [op_width-1:0]   write_reg_m,
  input  logic                  dmem_ready,
  input  logic [data_width-1:0] dmem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [data_width-1:0] dmem_addr,
  output logic [data_width-1:0] dmem_wdata,
  output logic                  stall_m,
  output logic                  align_err,
  output logic                  bus_err,
  output logic                  reg_write_w,
  output logic                  mem2reg_w,
  output logic [data_width-1:0] alu_result_w,
  output logic [data_width-1:0] read_data_w,
  output logic [op_width-1:0]   write_reg_w
);

  localparam int cnt_width = $clog2(timeout);
  localparam logic [cnt_width-1:0] last_cnt = cnt_width'(timeout - 1);

  state_t               state;
  logic [cnt_width-1:0] wait_cnt;

  logic                  mem_op;
  logic                  misaligned;
  logic                  abort;
  logic                  abort_taken;
  logic                  retire_reg_write;
  logic                  retire_mem2reg;
  logic [data_width-1:0] retire_read_data;

  // Request, stall and abort decode from EX/MEM contents and FSM state.
  always_comb begin
    mem_op      = mem2reg_m | mem_write_m;
    misaligned  = mem_op & word_misaligned(alu_result_m[1:0]);
    dmem_req    = mem_op & ~misaligned & ((state == ST_IDLE) | (state == ST_WAIT));
    dmem_we     = dmem_req & mem_write_m;
    dmem_addr   = alu_result_m;
    dmem_wdata  = write_data_m;
    abort       = (state == ST_WAIT) & (wait_cnt == last_cnt);
    abort_taken = abort & ~dmem_ready;
    stall_m     = dmem_req & ~dmem_ready & ~abort;
  end

  // Retire values: faulted accesses retire with write-back suppressed,
  // and load data is kept only when the memory actually completed it.
  always_comb begin
    retire_reg_write = reg_write_m & ~misaligned & ~abort_taken;
    retire_mem2reg   = mem2reg_m & ~misaligned;
    retire_read_data = '0;
    if (mem2reg_m & dmem_req & dmem_ready) begin
      retire_read_data = dmem_rdata;
    end
  end

  // IDLE/WAIT sequencing, wait counter and registered error pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      align_err <= (state == ST_IDLE) & misaligned;
      bus_err   <= abort_taken;
      case (state)
        ST_IDLE: begin
          if (dmem_req & ~dmem_ready) begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_WAIT: begin
          // Ready wins over a coincident abort; a vanished request also exits.
          if (!dmem_req || dmem_ready || abort) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + cnt_width'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  mem_wb_pipe_reg #(
    .data_width(data_width),
    .op_width  (op_width)
  ) u_mem_wb (
    .clk         (clk),
    .reset       (reset),
    .load        (~stall_m),
    .bubble      (stall_m),
    .reg_write_m (retire_reg_write),
    .mem2reg_m   (retire_mem2reg),
    .alu_result_m(alu_result_m),
    .read_data_m (retire_read_data),
    .write_reg_m (write_reg_m),
    .reg_write_w (reg_write_w),
    .mem2reg_w   (mem2reg_w),
    .alu_result_w(alu_result_w),
    .read_data_w (read_data_w),
    .write_reg_w (write_reg_w)
  );

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller of the 5-stage pipelined MIPS core; the consumer of the EX/MEM pipeline register outputs. Drives the data-memory port with a req/ready handshake, stalls upstream stages on wait states, checks word alignment, enforces a wait timeout, and registers results into the MEM/WB boundary for write-back.

## Interface
Parameters:
- data_width, 32, datapath and memory word width
- op_width, 5, register-file address width
- timeout, 16, maximum WAIT cycles before abort (≥2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- reg_write_m  in  1  write-back enable from EX/MEM
- mem2reg_m  in  1  load: write-back selects memory data
- mem_write_m  in  1  store
- alu_result_m  in  data_width  memory address / ALU result
- write_data_m  in  data_width  store data
- write_reg_m  in  op_width  destination register
- dmem_ready  in  1  memory completes access this cycle
- dmem_rdata  in  data_width  load data, valid when dmem_ready
- dmem_req  out  1  memory access request
- dmem_we  out  1  write enable (store)
- dmem_addr  out  data_width  = alu_result_m
- dmem_wdata  out  data_width  = write_data_m
- stall_m  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- align_err  out  1  one-cycle pulse, misaligned access
- bus_err  out  1  one-cycle pulse, timeout abort
- reg_write_w, mem2reg_w  out  1 each  MEM/WB controls
- alu_result_w, read_data_w  out  data_width each  MEM/WB data
- write_reg_w  out  op_width  MEM/WB destination

## Operation
- mem_op = mem2reg_m | mem_write_m; misaligned = mem_op & (alu_result_m[1:0] != 0).
- States: IDLE, WAIT. Counter wait_cnt counts WAIT cycles.
- dmem_req = mem_op & ~misaligned & (state==IDLE | state==WAIT); dmem_we = dmem_req & mem_write_m.
- stall_m = dmem_req & ~dmem_ready & ~abort, where abort = (state==WAIT) & (wait_cnt==timeout-1).
- IDLE: non-mem op → retire. mem_op & misaligned → no request, align_err pulse, retire with reg_write_w=0, mem2reg_w=0. dmem_req & dmem_ready → retire, read_data_w<=dmem_rdata. dmem_req & ~dmem_ready → WAIT, wait_cnt<=0.
- WAIT: dmem_ready → retire, IDLE. abort (no ready) → bus_err pulse, retire with reg_write_w=0, IDLE. Otherwise wait_cnt+1; dmem_ready wins if coincident with abort.
- Retire: MEM/WB captures reg_write_m, mem2reg_m, alu_result_m, write_reg_m; read_data_w captures dmem_rdata on completed loads, else 0.
- Stalled cycle: MEM/WB loads a bubble (reg_write_w=0, mem2reg_w=0, data/dest 0); EX/MEM contents held upstream by stall_m.
- Reset (any time, incl. mid-WAIT): IDLE, wait_cnt=0, all registered outputs 0, align_err/bus_err 0; dmem_req 0 since EX/MEM also resets to 0.

## Timing
- Zero-wait access: request and completion in same cycle; MEM/WB valid next edge; no stall.
- N-wait access: stall_m high N cycles; retire on edge where dmem_ready sampled high.
- Timeout: stall_m high exactly timeout cycles total (1 IDLE + timeout-1 WAIT), low in abort cycle.
- dmem_addr/dmem_wdata/dmem_we stable for whole request (EX/MEM frozen).
- align_err, bus_err registered: high one cycle after detection edge.

## Structure
- Package mem_stage_pkg: state encoding (IDLE, WAIT), bubble constants.
- Sub-module mem_wb_pipe_reg: MEM/WB register with load and bubble inputs, async active-low reset; controller instantiates it.

## Test plan
- Reset: drive outputs random mid-WAIT, assert reset → all outputs 0, state IDLE immediately.
- Zero-wait load: alu_result_m=0x100, mem2reg_m=1, reg_write_m=1, write_reg_m=8, dmem_ready=1, rdata=0xDEADBEEF → no stall; next edge read_data_w=0xDEADBEEF, write_reg_w=8, reg_write_w=1.
- 3-wait store: mem_write_m=1, addr 0x40, wdata 0x1234 → dmem_we=1 four cycles, stall_m high 3 cycles, MEM/WB bubbles 3 cycles then retire.
- Misaligned: load addr 0x102 → dmem_req=0, align_err pulse, reg_write_w=0.
- Timeout: dmem_ready tied 0, timeout=16 → stall_m high 16 cycles, bus_err pulse, reg_write_w=0; ready on final cycle instead → normal retire, no bus_err.
